// File: rtl/player_entry_bank_pkg.sv
// Shared definitions for the SUM game blocks: round states, default sizes, clog2 helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package game_pkg;

  // Round state of the entry bank.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam int DEF_WIDTH       = 4;
  localparam int DEF_NUM_PLAYERS = 4;

  // Ceiling log2; returns at least 1 so a select bus is never zero-width.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    if (result < 1) begin
      result = 1;
    end
    return result;
  endfunction

  localparam int DEF_PSEL_W = clog2(DEF_NUM_PLAYERS);

endpackage

// File: rtl/player_entry_bank_if.sv
// Bundle between the access controller / input decoder and the entry bank.
// Latency: n/a (wires only).
// Backpressure: none; refused loads are signalled on 'rejected'.
// Ports: master drives round_start/ld/splayer/player_sel/din and observes the bank state;
//        slave (the bank) drives q/valid/all_loaded/sum/rejected/busy.
interface player_entry_bank_if
  import game_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int NUM_PLAYERS = DEF_NUM_PLAYERS,
  parameter int PSEL_W      = DEF_PSEL_W,
  parameter int SUM_W       = WIDTH + PSEL_W
) ();

  logic                         round_start;
  logic                         ld;
  logic                         splayer;
  logic [PSEL_W-1:0]            player_sel;
  logic [WIDTH-1:0]             din;
  logic [NUM_PLAYERS*WIDTH-1:0] q;
  logic [NUM_PLAYERS-1:0]       valid;
  logic                         all_loaded;
  logic [SUM_W-1:0]             sum;
  logic                         rejected;
  logic                         busy;

  modport master (
    output round_start, ld, splayer, player_sel, din,
    input  q, valid, all_loaded, sum, rejected, busy
  );

  modport slave (
    input  round_start, ld, splayer, player_sel, din,
    output q, valid, all_loaded, sum, rejected, busy
  );

endinterface

// File: rtl/player_entry_bank_entry_slot.sv
// One player entry: a WIDTH-bit value plus an "entered" flag, cleared at round start.
// Latency: 1 cycle from i_ld to o_q/o_valid.
// Backpressure: none; the caller only pulses i_ld for accepted loads.
// Ports: clk, rst (sync active-low), i_clr, i_ld, i_din in; o_q, o_valid out.
module entry_slot
  import game_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_ld,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_q,
  output logic             o_valid
);

  logic [WIDTH-1:0] r_q;
  logic             r_valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q     <= '0;
      r_valid <= 1'b0;
    end else if (i_clr) begin
      r_q     <= '0;
      r_valid <= 1'b0;
    end else if (i_ld) begin
      r_q     <= i_din;
      r_valid <= 1'b1;
    end
  end

  assign o_q     = r_q;
  assign o_valid = r_valid;

endmodule

// File: rtl/player_entry_bank.sv
// Per-player entry bank: captures one authorised number per player per round and sums them.
// Latency: 1 cycle from an accepted ld to q/valid/sum; rejected pulses 1 cycle after a refused ld.
// Backpressure: none; refused loads are dropped and flagged on 'rejected'.
// Ports: clk, rst (sync active-low) plain; bus (slave) carries round_start/ld/splayer/player_sel/din
//        in and q/valid/all_loaded/sum/rejected/busy out.
module player_entry_bank
  import game_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int NUM_PLAYERS = DEF_NUM_PLAYERS,
  parameter int PSEL_W      = DEF_PSEL_W,
  parameter int SUM_W       = WIDTH + PSEL_W
) (
  input  logic                 clk,
  input  logic                 rst,
  player_entry_bank_if.slave   bus
);

  localparam logic [PSEL_W:0] LP_NUM_PLAYERS = (PSEL_W + 1)'(NUM_PLAYERS);

  state_t r_state;
  state_t w_state_nxt;

  logic [NUM_PLAYERS*WIDTH-1:0] w_q;
  logic [NUM_PLAYERS-1:0]       w_valid;
  logic [NUM_PLAYERS-1:0]       w_ld_vec;
  logic                         w_req;
  logic                         w_in_range;
  logic                         w_sel_valid;
  logic                         w_accept;
  logic                         w_reject;
  logic                         w_last;
  logic                         w_busy;
  logic                         w_all_loaded;
  logic [SUM_W-1:0]             r_sum;
  logic                         r_rejected;

  // Slot storage.
  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_slot
    entry_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (bus.round_start),
      .i_ld    (w_ld_vec[g]),
      .i_din   (bus.din),
      .o_q     (w_q[g*WIDTH +: WIDTH]),
      .o_valid (w_valid[g])
    );
  end

  // Valid flag of the selected slot; out-of-range selects read as "not valid"
  // and are refused by the range check instead.
  always_comb begin
    w_sel_valid = 1'b0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (bus.player_sel == PSEL_W'(i)) begin
        w_sel_valid = w_valid[i];
      end
    end
  end

  // round_start outranks ld, so a load arriving with it is neither taken nor flagged.
  // Unauthorised loads (splayer=0) never form a request at all.
  assign w_req      = bus.ld & bus.splayer & ~bus.round_start;
  assign w_in_range = ({1'b0, bus.player_sel} < LP_NUM_PLAYERS);

  // Accept/reject decode, per-slot load strobes, next state and status outputs.
  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_reject     = 1'b0;
    w_ld_vec     = '0;
    w_last       = 1'b0;
    w_busy       = 1'b0;
    w_all_loaded = 1'b0;

    w_accept = w_req && (r_state == COLLECT) && w_in_range && !w_sel_valid;
    w_reject = w_req && !w_accept;

    for (int i = 0; i < NUM_PLAYERS; i++) begin
      w_ld_vec[i] = w_accept && (bus.player_sel == PSEL_W'(i));
    end

    // This accept fills the final empty slot.
    w_last = &(w_valid | w_ld_vec);

    case (r_state)
      IDLE: begin
        if (bus.round_start) begin
          w_state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        w_busy = 1'b1;
        if (bus.round_start) begin
          w_state_nxt = COLLECT;
        end else if (w_accept && w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_all_loaded = 1'b1;
        if (bus.round_start) begin
          w_state_nxt = COLLECT;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Running sum of accepted entries; wraps modulo 2**SUM_W by definition.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sum <= '0;
    end else if (bus.round_start) begin
      r_sum <= '0;
    end else if (w_accept) begin
      r_sum <= r_sum + SUM_W'(bus.din);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rejected <= 1'b0;
    end else begin
      r_rejected <= w_reject;
    end
  end

  assign bus.q          = w_q;
  assign bus.valid      = w_valid;
  assign bus.sum        = r_sum;
  assign bus.rejected   = r_rejected;
  assign bus.busy       = w_busy;
  assign bus.all_loaded = w_all_loaded;

endmodule

// File: doc/player_entry_bank.md
Name: player_entry_bank

Overview:
Parametrised bank of per-player entry registers for the scrambled-number SUM game. It captures one validated number per player per round, gated by the access controller's `splayer` authorisation. It tracks which players have entered, rejects duplicate or unauthorised loads, and keeps a running sum of the round. It sits between the access controller / input decoder and the game scoring logic.

Parameters:
- WIDTH, 4: bits per player entry.
- NUM_PLAYERS, 4: number of player slots (≥2).
- PSEL_W, 2: width of `player_sel`; must satisfy 2**PSEL_W ≥ NUM_PLAYERS.
- SUM_W, WIDTH+PSEL_W: width of the running sum; holds NUM_PLAYERS*(2**WIDTH−1) without overflow.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-low.
- round_start  in  1  clears the bank and opens a new collection round.
- ld  in  1  load request for the slot selected by `player_sel`.
- splayer  in  1  player authorised by the access controller; a load needs `ld`=1 and `splayer`=1.
- player_sel  in  PSEL_W  target slot index.
- din  in  WIDTH  entry value.
- q  out  NUM_PLAYERS*WIDTH  registered entries; slot i occupies bits [i*WIDTH +: WIDTH].
- valid  out  NUM_PLAYERS  per-slot "entered this round" flags.
- all_loaded  out  1  high in DONE state.
- sum  out  SUM_W  running sum of accepted entries this round.
- rejected  out  1  one-cycle pulse when a load request is refused.
- busy  out  1  high in COLLECT state.

Behaviour:
- **Reset (rst=0 at edge):**
  - q=0, valid=0, sum=0, rejected=0, state=IDLE, so all_loaded=0 and busy=0.
  - rst overrides every other input.
- **States:** IDLE, COLLECT, DONE (2-bit encoding).
- **Priority per edge:** rst > round_start > ld.
- **round_start=1, any state:**
  - next edge: q=0, valid=0, sum=0, state=COLLECT, rejected=0.
  - A simultaneous ld is ignored: not loaded, not flagged.
- **Accept condition** (COLLECT only): ld=1, splayer=1, player_sel<NUM_PLAYERS, and valid[player_sel]=0.
  - On accept, at the next edge: q slot ← din; valid[sel] ← 1; sum ← sum + zero-extended din.
  - Latency is 1 cycle for all three updates.
  - If this accept sets the last valid bit, the state goes to DONE on the same edge.
- **Reject condition:** ld=1 with splayer=1 that does not meet the accept condition. Causes:
  - state is IDLE or DONE;
  - slot already valid;
  - player_sel out of range.
  - Effect: rejected=1 for exactly the next cycle; no register changes.
- **ld with splayer=0:** silently ignored, rejected stays 0. Unauthorised players are filtered upstream and must not raise an error.
- **rejected:** deasserts after one cycle unless another reject occurs.
- **DONE:** q, valid and sum hold until round_start or reset. all_loaded=1 and busy=0.
- **Sum width:** no wrap is possible with the default SUM_W; the sum is modulo 2**SUM_W by definition.
- **Repeated loads:** a slot can load only once per round. Its held value is never overwritten, unlike a plain load register.
- **round_start mid-round (COLLECT):** partial entries are discarded.
- **Reset mid-round:** returns to IDLE. A round_start is required before any loads are accepted.

Decomposition:
- **Shared package `game_pkg`:**
  - state typedef/localparams: IDLE=2'd0, COLLECT=2'd1, DONE=2'd2;
  - default WIDTH/NUM_PLAYERS constants;
  - a clog2 helper.
- **Sub-module `entry_slot`:** one WIDTH register plus valid bit, with clear, load and sync active-low reset. Instantiated NUM_PLAYERS times via generate.
- **Top:** the FSM, accept/reject decode, and the sum accumulator.

Test Plan:
- **Reset then loads without a round:** rst=0 for 2 cycles, then ld=1, splayer=1, sel=0, din=5 → q=0, valid=0, rejected pulses 1 cycle, state IDLE.
- **Full round:** round_start, then loads (sel,din) = (0,3), (1,15), (2,7), (3,9) on consecutive cycles.
  - Required: q=0x97F3 (slot 3 at the MSBs), sum=34, valid=4'b1111.
  - all_loaded rises the cycle after the 4th load; busy falls at the same time.
- **Duplicate load:** in COLLECT, load sel=1 din=4, then sel=1 din=8 → slot 1 stays 4, sum=4, rejected=1 for one cycle after the second load.
- **Unauthorised load:** ld=1, splayer=0, sel=2, din=6 → no change, rejected=0, valid[2]=0.
- **Priority and mid-round abort:** after two loads, assert round_start together with ld (sel=2, din=1) → q=0, sum=0, valid=0, state COLLECT, rejected=0.
- **Reset mid-round and max values:**
  - With valid=4'b0011, assert rst=0 → all outputs 0, state IDLE.
  - Then round_start and four loads of din=15 → sum=60, no overflow.
